icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache; the responder on the fetch-stage Icache interface.
- Takes fetch address/valid from the fetch stage and returns the instruction combinationally on hit, or stalls while a line refills from the memory port.
- Sits between the fetch stage and the instruction memory/bus. Supports a global invalidate for fence.i and exception recovery.

Parameters:
- NUM_LINES, 16, number of cache lines; power of 2, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2.
- Derived values:
  - OFS = log2(LINE_WORDS)
  - IDX = log2(NUM_LINES)
  - TAG_W = 30 - OFS - IDX

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ADR_SI  in  32  fetch address; bits [1:0] ignored.
- ADR_VALID_SI  in  1  fetch request valid this cycle.
- IC_INST_SI  out  32  instruction word for ADR_SI; valid when IC_STALL_SI=0 and ADR_VALID_SI=1.
- IC_STALL_SI  out  1  fetch must hold; instruction not available.
- IC_FLUSH_SI  in  1  invalidate all lines.
- MEM_REQ_SC  out  1  line refill request.
- MEM_ADR_SC  out  32  line base address (low OFS+2 bits zero).
- MEM_ACK_SM  in  1  memory accepted request.
- MEM_DATA_SM  in  32  refill data beat.
- MEM_DATA_VALID_SM  in  1  MEM_DATA_SM valid this cycle.

Behaviour:
- Address split:
  - word offset = ADR_SI[OFS+1:2]
  - index = ADR_SI[OFS+IDX+1:OFS+2]
  - tag = ADR_SI[31:OFS+IDX+2]
- Storage:
  - data array NUM_LINES×LINE_WORDS×32, not reset.
  - tag array, not reset.
  - valid vector NUM_LINES, cleared on reset.
- hit = ADR_VALID_SI & valid[index] & (tag_array[index]==tag) & state==IDLE. Purely combinational, zero latency.
- IC_INST_SI = data[index][offset] on hit, else 32'h00000013 (nop).
- IC_STALL_SI = ADR_VALID_SI & !hit.
  - ADR_VALID_SI=0 -> IC_STALL_SI=0 in every state.
- FSM states: IDLE, REQ, FILL, DONE.
  - IDLE:
    - On ADR_VALID_SI & !hit & !IC_FLUSH_SI: latch line base {ADR_SI[31:OFS+2], zeros} into fill_adr, go to REQ.
    - IC_FLUSH_SI in IDLE: clear all valid bits that cycle; no refill starts that cycle.
  - REQ:
    - MEM_REQ_SC=1, MEM_ADR_SC=fill_adr, held stable until MEM_ACK_SM=1.
    - On ack: beat counter := 0, go to FILL.
    - MEM_ACK_SM is sampled only in REQ.
  - FILL:
    - Each MEM_DATA_VALID_SM cycle: data[fill_idx][cnt] := MEM_DATA_SM, cnt++.
    - Gaps between beats are allowed.
    - On the beat with cnt==LINE_WORDS-1: write the tag, set valid[fill_idx] unless a flush is pending, go to DONE.
  - DONE: one cycle, stall still asserted. Go to IDLE; the held request then hits.
- Miss penalty = 1 (REQ min) + ack wait + LINE_WORDS beats + 1 (DONE) + lookup cycle.
- Refill is non-abortable. It completes even if ADR_VALID_SI drops or ADR_SI changes mid-refill, e.g. fetch redirect or flush.
- IC_FLUSH_SI during REQ/FILL/DONE:
  - set flush_pending.
  - the line being filled is written but not marked valid.
  - all valid bits are cleared on entry to IDLE.
  - flush_pending is cleared there.
- MEM_DATA_VALID_SM outside FILL is ignored.
- MEM_REQ_SC=0 and MEM_ADR_SC=0 outside REQ.
- Eviction: a refill overwrites the line at fill_idx unconditionally; no write-back (read-only).
- Reset, including mid-refill:
  - state=IDLE, valid=0, flush_pending=0, cnt=0.
  - MEM_REQ_SC=0, MEM_ADR_SC=0.
  - IC_STALL_SI follows ADR_VALID_SI; IC_INST_SI=nop.
  - Memory beats of the aborted burst arriving after reset are ignored.

Test Plan:
- Cold miss: reset, ADR_SI=0x100 valid. Required:
  - IC_STALL_SI=1.
  - MEM_REQ_SC=1 with MEM_ADR_SC=0x100 until ack (ack 2 cycles later).
  - 4 beats 0xA0..0xA3, stall held through DONE.
  - Next cycle IC_INST_SI=0xA0, stall=0.
  - ADR_SI=0x10C then hits with 0xA3.
- Beat gaps: refill with MEM_DATA_VALID_SM pattern 1,0,0,1,1,0,1 -> exactly 4 words captured in order; line valid after the 4th beat; no extra memory request.
- Conflict: fill 0x100, then request 0x500 (same index 0, different tag) -> miss and refill at 0x500; 0x100 then misses again.
- Idle/no-request: ADR_VALID_SI=0 with any ADR_SI -> IC_STALL_SI=0, IC_INST_SI=0x13, MEM_REQ_SC never asserts.
- Flush mid-refill: pulse IC_FLUSH_SI during FILL of 0x200; preload 0x100 valid. Required:
  - the refill finishes its 4 beats.
  - both 0x100 and 0x200 then miss.
  - a new MEM_REQ_SC for 0x200 is issued.
- Reset mid-refill: assert reset after 2 beats -> next cycle MEM_REQ_SC=0, all lookups miss; stale beats after reset do not write or validate any line.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache.
// The hit path is combinational. A miss refills a whole line from the memory
// port through a REQ -> FILL -> DONE sequence, and the fetch stage is stalled
// meanwhile. A global flush invalidates every line.
module icache_dm #(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ADR_SI,
    input  logic        ADR_VALID_SI,
    output logic [31:0] IC_INST_SI,
    output logic        IC_STALL_SI,
    input  logic        IC_FLUSH_SI,
    output logic        MEM_REQ_SC,
    output logic [31:0] MEM_ADR_SC,
    input  logic        MEM_ACK_SM,
    input  logic [31:0] MEM_DATA_SM,
    input  logic        MEM_DATA_VALID_SM
);

    localparam int unsigned OFS   = $clog2(LINE_WORDS);
    localparam int unsigned IDX   = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 30 - OFS - IDX;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [OFS-1:0]       cnt_q, cnt_d;
    logic [31:0]          fill_adr_q, fill_adr_d;

    logic [31:0]          data_q [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];

    logic [OFS-1:0]       a_ofs;
    logic [IDX-1:0]       a_idx;
    logic [TAG_W-1:0]     a_tag;
    logic [IDX-1:0]       fill_idx;
    logic [TAG_W-1:0]     fill_tag;
    logic                 hit;
    logic                 flush_any;
    logic                 data_we;
    logic                 tag_we;
    logic                 unused_ok;

    assign a_ofs     = ADR_SI[OFS+1:2];
    assign a_idx     = ADR_SI[OFS+IDX+1:OFS+2];
    assign a_tag     = ADR_SI[31:OFS+IDX+2];
    assign fill_idx  = fill_adr_q[OFS+IDX+1:OFS+2];
    assign fill_tag  = fill_adr_q[31:OFS+IDX+2];
    assign unused_ok = ^ADR_SI[1:0];

    assign hit         = ADR_VALID_SI & valid_q[a_idx] & (tag_q[a_idx] == a_tag) & (state_q == IDLE);
    assign IC_INST_SI  = hit ? data_q[{a_idx, a_ofs}] : NOP;
    assign IC_STALL_SI = ADR_VALID_SI & ~hit;
    assign flush_any   = flush_pend_q | IC_FLUSH_SI;

    // Next-state, refill bookkeeping and memory-port outputs.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        fill_adr_d   = fill_adr_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        MEM_REQ_SC   = 1'b0;
        MEM_ADR_SC   = '0;
        case (state_q)
            IDLE: begin
                if (IC_FLUSH_SI) begin
                    valid_d = '0;
                end else if (ADR_VALID_SI && !hit) begin
                    fill_adr_d = {ADR_SI[31:OFS+2], {(OFS+2){1'b0}}};
                    state_d    = REQ;
                end
            end
            REQ: begin
                MEM_REQ_SC = 1'b1;
                MEM_ADR_SC = fill_adr_q;
                if (IC_FLUSH_SI) flush_pend_d = 1'b1;
                if (MEM_ACK_SM) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (IC_FLUSH_SI) flush_pend_d = 1'b1;
                if (MEM_DATA_VALID_SM) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFS'(1);
                    if (cnt_q == OFS'(LINE_WORDS - 1)) begin
                        tag_we = 1'b1;
                        // A flush seen at any point of the refill, including
                        // this final beat, keeps the new line invalid.
                        if (!flush_any) valid_d[fill_idx] = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Deferred flush lands on the way back to IDLE.
                if (flush_any) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            fill_adr_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            fill_adr_q   <= fill_adr_d;
        end
    end

    // Data and tag storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (data_we) data_q[{fill_idx, cnt_q}] <= MEM_DATA_SM;
        if (tag_we)  tag_q[fill_idx]          <= fill_tag;
    end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: a fetch driver pushes expected responses,
// a negedge monitor pops and checks them, and a memory model serves refills.
module tb_icache_dm;

    localparam int unsigned NL  = 16;
    localparam int unsigned LW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ADR_SI;
    logic        ADR_VALID_SI;
    logic [31:0] IC_INST_SI;
    logic        IC_STALL_SI;
    logic        IC_FLUSH_SI;
    logic        MEM_REQ_SC;
    logic [31:0] MEM_ADR_SC;
    logic        MEM_ACK_SM;
    logic [31:0] MEM_DATA_SM;
    logic        MEM_DATA_VALID_SM;

    always #5 clk = ~clk;

    icache_dm #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset),
        .ADR_SI(ADR_SI), .ADR_VALID_SI(ADR_VALID_SI),
        .IC_INST_SI(IC_INST_SI), .IC_STALL_SI(IC_STALL_SI),
        .IC_FLUSH_SI(IC_FLUSH_SI),
        .MEM_REQ_SC(MEM_REQ_SC), .MEM_ADR_SC(MEM_ADR_SC),
        .MEM_ACK_SM(MEM_ACK_SM), .MEM_DATA_SM(MEM_DATA_SM),
        .MEM_DATA_VALID_SM(MEM_DATA_VALID_SM)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        bit          hit;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        sbq[$];
    int unsigned exp_reqs  = 0;
    int unsigned seen_reqs = 0;
    int unsigned stall_cnt = 0;

    // Reference model: which line (by tag) is resident at each index.
    bit          mv[NL];
    int unsigned mt[NL];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h2468_ACE1;
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] a);
        return (a / (LW * 4)) % NL;
    endfunction

    function automatic int unsigned m_tag(input logic [31:0] a);
        return a / (LW * 4 * NL);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic end_sim();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    endtask

    // Monitor: pops one expectation each time a valid fetch is served.
    always @(negedge clk) begin
        if (reset) begin
            stall_cnt = 0;
        end else if (!ADR_VALID_SI) begin
            stall_cnt = 0;
            check("idle_stall", {31'd0, IC_STALL_SI}, 32'd0);
            check("idle_inst", IC_INST_SI, NOP);
        end else if (IC_STALL_SI) begin
            stall_cnt++;
        end else if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_response: actual=%h required=none", IC_INST_SI);
        end else begin
            exp_t e;
            e = sbq.pop_front();
            check($sformatf("inst@%h", e.adr), IC_INST_SI, e.data);
            check($sformatf("hit@%h", e.adr), {31'd0, stall_cnt == 0}, {31'd0, e.hit});
            stall_cnt = 0;
        end
    end

    // Memory model: random ack delay, random gaps between beats.
    initial begin
        logic [31:0] base;
        MEM_ACK_SM        = 1'b0;
        MEM_DATA_VALID_SM = 1'b0;
        MEM_DATA_SM       = '0;
        forever begin
            @(negedge clk);
            if (MEM_REQ_SC && !reset) begin
                base = MEM_ADR_SC;
                seen_reqs++;
                check("mem_adr_align", base & (LW * 4 - 1), 32'd0);
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                    check("req_hold", {31'd0, MEM_REQ_SC}, 32'd1);
                    check("adr_hold", MEM_ADR_SC, base);
                end
                @(posedge clk); #1 MEM_ACK_SM = 1'b1;
                @(posedge clk); #1 MEM_ACK_SM = 1'b0;
                for (int unsigned i = 0; i < LW; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        MEM_DATA_SM = $urandom;
                        @(posedge clk); #1;
                    end
                    MEM_DATA_SM       = memfn(base + 4 * i);
                    MEM_DATA_VALID_SM = 1'b1;
                    @(posedge clk); #1;
                    MEM_DATA_VALID_SM = 1'b0;
                    MEM_DATA_SM       = $urandom;
                end
            end
        end
    end

    task automatic pulse_flush_on_beat();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (MEM_DATA_VALID_SM) break;
        end
        IC_FLUSH_SI = 1'b1;
        @(posedge clk); #1 IC_FLUSH_SI = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input bit flush_mid);
        exp_t e;
        bit   h;
        bit   done;
        h = mv[m_idx(a)] && (mt[m_idx(a)] == m_tag(a));
        if (h) flush_mid = 1'b0;
        e.adr  = a;
        e.data = memfn(a);
        e.hit  = h;
        if (!h) exp_reqs += flush_mid ? 2 : 1;
        sbq.push_back(e);
        ADR_SI       = a;
        ADR_VALID_SI = 1'b1;
        if (flush_mid) fork pulse_flush_on_beat(); join_none
        done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!IC_STALL_SI) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL fetch_timeout@%h: actual=stalled required=served", a);
            end_sim();
        end
        if (flush_mid) model_clear();
        mv[m_idx(a)] = 1'b1;
        mt[m_idx(a)] = m_tag(a);
        @(posedge clk); #1;
    endtask

    task automatic flush_idle();
        ADR_VALID_SI = 1'b0;
        IC_FLUSH_SI  = 1'b1;
        @(posedge clk); #1 IC_FLUSH_SI = 1'b0;
        model_clear();
    endtask

    initial begin
        #600000;
        tests++;
        fails++;
        $display("FAIL watchdog: actual=running required=finished");
        end_sim();
    end

    initial begin
        logic [31:0] tags [4];
        logic [31:0] a;
        int          beats;
        tags[0] = 32'h0;
        tags[1] = 32'h1;
        tags[2] = 32'h5;
        tags[3] = 32'hFF_FFFF;
        model_clear();
        reset        = 1'b1;
        ADR_SI       = '0;
        ADR_VALID_SI = 1'b0;
        IC_FLUSH_SI  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, with and without a pending fetch.
        @(negedge clk);
        check("rst_req", {31'd0, MEM_REQ_SC}, 32'd0);
        check("rst_adr", MEM_ADR_SC, 32'd0);
        check("rst_stall_novalid", {31'd0, IC_STALL_SI}, 32'd0);
        ADR_SI = 32'h100;
        ADR_VALID_SI = 1'b1;
        @(negedge clk);
        check("rst_stall_valid", {31'd0, IC_STALL_SI}, 32'd1);
        check("rst_inst", IC_INST_SI, NOP);
        check("rst_req_valid", {31'd0, MEM_REQ_SC}, 32'd0);
        ADR_VALID_SI = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        // Cold miss, hit in same line, conflict eviction, flush mid-refill.
        fetch(32'h100, 1'b0);
        fetch(32'h10C, 1'b0);
        fetch(32'h500, 1'b0);
        fetch(32'h100, 1'b0);
        fetch(32'h200, 1'b1);
        fetch(32'h100, 1'b0);
        fetch(32'h204, 1'b0);

        // No request: outputs idle regardless of address.
        ADR_VALID_SI = 1'b0;
        repeat (8) begin
            ADR_SI = $urandom;
            @(posedge clk); #1;
        end

        flush_idle();
        fetch(32'h204, 1'b0);

        // Reset after two beats of a refill; the remaining beats are stale.
        flush_idle();
        exp_reqs++;
        ADR_SI = 32'h300;
        ADR_VALID_SI = 1'b1;
        beats = 0;
        for (int c = 0; c < 200 && beats < 2; c++) begin
            @(negedge clk);
            if (MEM_DATA_VALID_SM) beats++;
        end
        check("rstmid_beats", beats, 32'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        ADR_VALID_SI = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rstmid_req", {31'd0, MEM_REQ_SC}, 32'd0);
        check("rstmid_adr", MEM_ADR_SC, 32'd0);
        model_clear();
        repeat (20) @(posedge clk);
        #1;
        fetch(32'h300, 1'b0);
        fetch(32'h308, 1'b0);

        // Randomised mix over a small address pool to get hits and conflicts.
        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            a = (tags[$urandom_range(0, 3)] << 8) | ($urandom_range(0, NL - 1) << 4)
              | ($urandom_range(0, LW - 1) << 2) | $urandom_range(0, 3);
            if (r == 0) begin
                ADR_VALID_SI = 1'b0;
                ADR_SI = $urandom;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end else if (r == 1) begin
                flush_idle();
            end else begin
                fetch(a, r == 2);
            end
        end

        ADR_VALID_SI = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("sb_empty", sbq.size(), 32'd0);
        check("mem_req_count", seen_reqs, exp_reqs);
        end_sim();
    end

endmodule
